// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the MIPS pipeline registers: register-number width,
// reset PC, PC step and the packed-channel slicing helper.
package cpu_pipe_pkg;

  localparam int          A3_W     = 5;
  localparam logic [4:0]  A3_ZERO  = 5'd0;
  localparam logic [31:0] PC_RST_D = 32'h0000_3000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  // LSB position of channel k in a bus of DW-wide packed channels.
  function automatic int chan_lsb(input int k, input int dw);
    return k * dw;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter: counts up on inc, sticks at all-ones, cleared
// only by reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Next value with saturation at the maximum code instead of wrapping.
  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  logic [W-1:0] cnt_p1;

  // Counter register; reset beats a coincident increment.
  always_ff @(posedge clk) begin
    if (reset)    cnt_p1 <= '0;
    else if (inc) cnt_p1 <= sat_inc(cnt_p1);
  end

  assign q = cnt_p1;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register for the 5-stage MIPS core.
// Carries valid, A3, NCH data channels, PC and PC+4 with stall (hold) and
// flush (bubble) control plus saturating stall/flush event counters.
module pipe_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int          DW               = 32,
  parameter int          NCH              = 2,
  parameter logic [31:0] PC_RST           = PC_RST_D,
  parameter bit          KEEP_PC_ON_FLUSH = 1'b1,
  parameter int          CNT_W            = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [A3_W-1:0]   in_a3,
  input  logic [NCH*DW-1:0] in_data,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_pc4,
  output logic              out_valid,
  output logic [A3_W-1:0]   out_a3,
  output logic [NCH*DW-1:0] out_data,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_pc4,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [31:0] PC4_RST = PC_RST + PC_STEP;

  logic              vld_p1;
  logic [A3_W-1:0]   a3_p1;
  logic [NCH*DW-1:0] data_p1;
  logic [31:0]       pc_p1;
  logic [31:0]       pc4_p1;

  // ---- stage boundary: input -> registered outputs ----

  // Control and A3: an invalid or flushed slot always carries A3=0 so it can
  // never match a forwarding source or write the register file.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      vld_p1 <= 1'b0;
      a3_p1  <= A3_ZERO;
    end else if (!stall) begin
      vld_p1 <= in_valid;
      a3_p1  <= in_valid ? in_a3 : A3_ZERO;
    end
  end

  // PC pair: a bubble optionally keeps the incoming PC for EPC tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_p1  <= PC_RST;
      pc4_p1 <= PC4_RST;
    end else if (flush) begin
      pc_p1  <= KEEP_PC_ON_FLUSH ? in_pc  : PC_RST;
      pc4_p1 <= KEEP_PC_ON_FLUSH ? in_pc4 : PC4_RST;
    end else if (!stall) begin
      pc_p1  <= in_pc;
      pc4_p1 <= in_pc4;
    end
  end

  // Data channels, one register per channel slice.
  for (genvar k = 0; k < NCH; k++) begin : g_chan
    always_ff @(posedge clk) begin
      if (reset || flush)
        data_p1[chan_lsb(k, DW) +: DW] <= '0;
      else if (!stall)
        data_p1[chan_lsb(k, DW) +: DW] <= in_data[chan_lsb(k, DW) +: DW];
    end
  end

  assign out_valid = vld_p1;
  assign out_a3    = a3_p1;
  assign out_data  = data_p1;
  assign out_pc    = pc_p1;
  assign out_pc4   = pc4_p1;

  // A flush overrides a coincident stall, so that cycle is not a stall event.
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall & ~flush),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush),
    .q     (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed testbench for pipe_stage_reg: default instance, a
// KEEP_PC_ON_FLUSH=0 instance and a CNT_W=2 instance share the same inputs.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset, stall, flush, in_valid;
  logic [4:0]  in_a3;
  logic [63:0] in_data;
  logic [31:0] in_pc, in_pc4;

  logic        o_valid;
  logic [4:0]  o_a3;
  logic [63:0] o_data;
  logic [31:0] o_pc, o_pc4;
  logic [15:0] o_scnt, o_fcnt;

  logic        k_valid;
  logic [4:0]  k_a3;
  logic [63:0] k_data;
  logic [31:0] k_pc, k_pc4;
  logic [15:0] k_scnt, k_fcnt;

  logic        c_valid;
  logic [4:0]  c_a3;
  logic [63:0] c_data;
  logic [31:0] c_pc, c_pc4;
  logic [1:0]  c_scnt, c_fcnt;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_a3(in_a3), .in_data(in_data),
    .in_pc(in_pc), .in_pc4(in_pc4),
    .out_valid(o_valid), .out_a3(o_a3), .out_data(o_data),
    .out_pc(o_pc), .out_pc4(o_pc4), .stall_cnt(o_scnt), .flush_cnt(o_fcnt)
  );

  pipe_stage_reg #(.KEEP_PC_ON_FLUSH(1'b0)) dut_k0 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_a3(in_a3), .in_data(in_data),
    .in_pc(in_pc), .in_pc4(in_pc4),
    .out_valid(k_valid), .out_a3(k_a3), .out_data(k_data),
    .out_pc(k_pc), .out_pc4(k_pc4), .stall_cnt(k_scnt), .flush_cnt(k_fcnt)
  );

  pipe_stage_reg #(.CNT_W(2)) dut_c2 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_a3(in_a3), .in_data(in_data),
    .in_pc(in_pc), .in_pc4(in_pc4),
    .out_valid(c_valid), .out_a3(c_a3), .out_data(c_data),
    .out_pc(c_pc), .out_pc4(c_pc4), .stall_cnt(c_scnt), .flush_cnt(c_fcnt)
  );

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] a3, input logic [63:0] d,
                       input logic [31:0] pc, input logic [31:0] pc4);
    in_valid = v; in_a3 = a3; in_data = d; in_pc = pc; in_pc4 = pc4;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 5'd17, 64'hAAAA_5555_1111_2222, 32'h0000_4444, 32'h0000_4448);
    step();
    reset = 1'b0;
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0h want 0", o_valid); end
    n_cmp++; if (o_a3 !== 5'd0) begin n_fail++; $display("FAIL rst_a3: got %0h want 0", o_a3); end
    n_cmp++; if (o_data !== 64'd0) begin n_fail++; $display("FAIL rst_data: got %0h want 0", o_data); end
    n_cmp++; if (o_pc !== 32'h3000) begin n_fail++; $display("FAIL rst_pc: got %0h want 3000", o_pc); end
    n_cmp++; if (o_pc4 !== 32'h3004) begin n_fail++; $display("FAIL rst_pc4: got %0h want 3004", o_pc4); end
    n_cmp++; if (o_scnt !== 16'd0) begin n_fail++; $display("FAIL rst_scnt: got %0d want 0", o_scnt); end
    n_cmp++; if (o_fcnt !== 16'd0) begin n_fail++; $display("FAIL rst_fcnt: got %0d want 0", o_fcnt); end
  endtask

  task automatic test_load();
    drive(1'b1, 5'd8, {32'h0000_1234, 32'hDEAD_BEEF}, 32'h3010, 32'h3014);
    step();
    n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL load_valid: got %0h want 1", o_valid); end
    n_cmp++; if (o_a3 !== 5'd8) begin n_fail++; $display("FAIL load_a3: got %0d want 8", o_a3); end
    n_cmp++; if (o_data[31:0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_ch0: got %0h want deadbeef", o_data[31:0]); end
    n_cmp++; if (o_data[63:32] !== 32'h1234) begin n_fail++; $display("FAIL load_ch1: got %0h want 1234", o_data[63:32]); end
    n_cmp++; if (o_pc !== 32'h3010) begin n_fail++; $display("FAIL load_pc: got %0h want 3010", o_pc); end
    n_cmp++; if (o_pc4 !== 32'h3014) begin n_fail++; $display("FAIL load_pc4: got %0h want 3014", o_pc4); end
  endtask

  task automatic test_stall();
    drive(1'b1, 5'd8, {32'h0000_1234, 32'hDEAD_BEEF}, 32'h3010, 32'h3014);
    step();
    stall = 1'b1;
    drive(1'b1, 5'd9, {32'h0000_5678, 32'hCAFE_F00D}, 32'h3020, 32'h3024);
    for (int i = 1; i <= 3; i++) begin
      step();
      n_cmp++; if (o_a3 !== 5'd8) begin n_fail++; $display("FAIL stall_a3[%0d]: got %0d want 8", i, o_a3); end
      n_cmp++; if (o_pc !== 32'h3010) begin n_fail++; $display("FAIL stall_pc[%0d]: got %0h want 3010", i, o_pc); end
      n_cmp++; if (o_data[31:0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL stall_ch0[%0d]: got %0h want deadbeef", i, o_data[31:0]); end
      n_cmp++; if (o_scnt !== 16'(i)) begin n_fail++; $display("FAIL stall_cnt[%0d]: got %0d want %0d", i, o_scnt, i); end
    end
    stall = 1'b0;
    step();
    n_cmp++; if (o_a3 !== 5'd9) begin n_fail++; $display("FAIL release_a3: got %0d want 9", o_a3); end
    n_cmp++; if (o_pc !== 32'h3020) begin n_fail++; $display("FAIL release_pc: got %0h want 3020", o_pc); end
    n_cmp++; if (o_scnt !== 16'd3) begin n_fail++; $display("FAIL release_scnt: got %0d want 3", o_scnt); end
  endtask

  task automatic test_flush();
    stall = 1'b1; flush = 1'b1;
    drive(1'b1, 5'd12, 64'h1111_2222_3333_4444, 32'h3040, 32'h3044);
    step();
    stall = 1'b0; flush = 1'b0;
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %0h want 0", o_valid); end
    n_cmp++; if (o_a3 !== 5'd0) begin n_fail++; $display("FAIL flush_a3: got %0d want 0", o_a3); end
    n_cmp++; if (o_data !== 64'd0) begin n_fail++; $display("FAIL flush_data: got %0h want 0", o_data); end
    n_cmp++; if (o_pc !== 32'h3040) begin n_fail++; $display("FAIL flush_pc: got %0h want 3040", o_pc); end
    n_cmp++; if (o_pc4 !== 32'h3044) begin n_fail++; $display("FAIL flush_pc4: got %0h want 3044", o_pc4); end
    n_cmp++; if (o_fcnt !== 16'd1) begin n_fail++; $display("FAIL flush_fcnt: got %0d want 1", o_fcnt); end
    n_cmp++; if (o_scnt !== 16'd3) begin n_fail++; $display("FAIL flush_scnt: got %0d want 3", o_scnt); end
    n_cmp++; if (k_pc !== 32'h3000) begin n_fail++; $display("FAIL flush_k0_pc: got %0h want 3000", k_pc); end
    n_cmp++; if (k_pc4 !== 32'h3004) begin n_fail++; $display("FAIL flush_k0_pc4: got %0h want 3004", k_pc4); end
    n_cmp++; if (k_a3 !== 5'd0) begin n_fail++; $display("FAIL flush_k0_a3: got %0d want 0", k_a3); end
  endtask

  task automatic test_invalid();
    drive(1'b0, 5'd31, 64'h0BAD_0BAD_0123_4567, 32'h3050, 32'h3054);
    step();
    n_cmp++; if (o_a3 !== 5'd0) begin n_fail++; $display("FAIL inv_a3: got %0d want 0", o_a3); end
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL inv_valid: got %0h want 0", o_valid); end
    n_cmp++; if (o_data !== 64'h0BAD_0BAD_0123_4567) begin n_fail++; $display("FAIL inv_data: got %0h want 0bad0bad01234567", o_data); end
    n_cmp++; if (o_pc !== 32'h3050) begin n_fail++; $display("FAIL inv_pc: got %0h want 3050", o_pc); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  a3s [3] = '{5'd1, 5'd2, 5'd3};
    logic [31:0] pcs [3] = '{32'h3100, 32'h3104, 32'h3108};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, a3s[i], {32'(i), 32'hF000_0000 | 32'(i)}, pcs[i], pcs[i] + 32'd4);
      step();
      n_cmp++; if (o_a3 !== a3s[i]) begin n_fail++; $display("FAIL b2b_a3[%0d]: got %0d want %0d", i, o_a3, a3s[i]); end
      n_cmp++; if (o_pc4 !== pcs[i] + 32'd4) begin n_fail++; $display("FAIL b2b_pc4[%0d]: got %0h want %0h", i, o_pc4, pcs[i] + 32'd4); end
      n_cmp++; if (o_data[63:32] !== 32'(i)) begin n_fail++; $display("FAIL b2b_ch1[%0d]: got %0h want %0h", i, o_data[63:32], i); end
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_c [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    step();
    reset = 1'b0; stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++; if (c_scnt !== exp_c[i]) begin n_fail++; $display("FAIL sat_scnt[%0d]: got %0d want %0d", i, c_scnt, exp_c[i]); end
    end
    n_cmp++; if (o_scnt !== 16'd6) begin n_fail++; $display("FAIL wide_scnt: got %0d want 6", o_scnt); end
    // Reset while stalling: counter clears and contents return to reset values.
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++; if (c_scnt !== 2'd0) begin n_fail++; $display("FAIL sat_rst_scnt: got %0d want 0", c_scnt); end
    n_cmp++; if (o_pc !== 32'h3000) begin n_fail++; $display("FAIL sat_rst_pc: got %0h want 3000", o_pc); end
    step();
    n_cmp++; if (c_scnt !== 2'd1) begin n_fail++; $display("FAIL sat_resume_scnt: got %0d want 1", c_scnt); end
    stall = 1'b0;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 5'd0, 64'd0, 32'd0, 32'd0);
    @(negedge clk);
    test_reset();
    test_load();
    test_stall();
    test_flush();
    test_invalid();
    test_back_to_back();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
